lbp_stream_engine: RTL and testbench

//  Streaming 3x3 Local Binary Pattern engine; parametrised successor of the fixed 128x128 LBP block.

---
 rtl/lbp_pkg.sv | 36 +++
 rtl/lbp_line_buffer.sv | 55 +++++
 rtl/lbp_stream_engine.sv | 148 ++++++++++++++
 tb/tb_lbp_stream_engine.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
// Shared types and constants for the streaming 3x3 LBP engine.
package lbp_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_FLUSH,
    S_DONE
  } lbp_state_t;

  typedef enum logic {
    BORDER_SKIP  = 1'b0,
    BORDER_WRITE = 1'b1
  } border_mode_t;

  // Window slots are numbered g0..g8 in raster order; code bit i compares slot NBR_IDX[i].
  localparam int G_CENTRE = 4;
  localparam int NBR_IDX [8] = '{0, 1, 2, 3, 5, 6, 7, 8};

  localparam logic [7:0] MASK_TOP   = 8'b0000_0111;
  localparam logic [7:0] MASK_BOT   = 8'b1110_0000;
  localparam logic [7:0] MASK_LEFT  = 8'b0010_1001;
  localparam logic [7:0] MASK_RIGHT = 8'b1001_0100;

  function automatic logic [7:0] border_keep(input logic top, input logic bot,
                                             input logic left, input logic right);
    logic [7:0] drop;
    drop = '0;
    if (top)   drop = drop | MASK_TOP;
    if (bot)   drop = drop | MASK_BOT;
    if (left)  drop = drop | MASK_LEFT;
    if (right) drop = drop | MASK_RIGHT;
    return ~drop;
  endfunction

endpackage

// File: rtl/lbp_line_buffer.sv
// Two row-delay FIFOs plus a 3x3 window; win shows the window as it will be after the current shift.
module lbp_line_buffer
  import lbp_pkg::*;
#(
  parameter int IMG_W = 128,
  parameter int DW    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               shift_en,
  input  logic [DW-1:0]      pix_in,
  output logic [8:0][DW-1:0] win
);

  logic [IMG_W-1:0][DW-1:0] row0;
  logic [IMG_W-1:0][DW-1:0] row1;
  logic [1:0][DW-1:0]       top_col;
  logic [1:0][DW-1:0]       mid_col;
  logic [1:0][DW-1:0]       bot_col;
  logic [DW-1:0]            tap0;
  logic [DW-1:0]            tap1;

  // tap0 is the pixel one row above the incoming one, tap1 two rows above.
  assign tap0 = row0[IMG_W-1];
  assign tap1 = row1[IMG_W-1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      row0    <= '0;
      row1    <= '0;
      top_col <= '0;
      mid_col <= '0;
      bot_col <= '0;
    end else if (shift_en) begin
      row0    <= {row0[IMG_W-2:0], pix_in};
      row1    <= {row1[IMG_W-2:0], tap0};
      top_col <= {tap1, top_col[1]};
      mid_col <= {tap0, mid_col[1]};
      bot_col <= {pix_in, bot_col[1]};
    end
  end

  always_comb begin
    win[0]        = top_col[0];
    win[1]        = top_col[1];
    win[2]        = tap1;
    win[3]        = mid_col[0];
    win[G_CENTRE] = mid_col[1];
    win[5]        = tap0;
    win[6]        = bot_col[0];
    win[7]        = bot_col[1];
    win[8]        = pix_in;
  end

endmodule

// File: rtl/lbp_stream_engine.sv
// Streaming 3x3 LBP engine: raster reads from gray memory, one code per centre pixel to the result memory.
module lbp_stream_engine
  import lbp_pkg::*;
#(
  parameter int IMG_W       = 128,
  parameter int IMG_H       = 128,
  parameter int DW          = 8,
  parameter int AW          = 14,
  parameter int BORDER_MODE = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] lbp_thresh,
  output logic [AW-1:0] gray_addr,
  output logic          gray_req,
  input  logic          gray_ready,
  input  logic [DW-1:0] gray_data,
  output logic [AW-1:0] lbp_addr,
  output logic          lbp_valid,
  output logic [7:0]    lbp_data,
  output logic          finish
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [AW-1:0] LAST_IDX   = AW'(IMG_W * IMG_H - 1);
  localparam logic [AW-1:0] FIRST_EMIT = AW'(IMG_W + 1);
  localparam logic [CW-1:0] LAST_COL   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW   = RW'(IMG_H - 1);
  localparam bit WRITE_BORDER = (BORDER_MODE == int'(BORDER_WRITE));

  lbp_state_t        state;
  logic [DW-1:0]     thr;
  logic              cap_pend;
  logic [AW-1:0]     cap_idx;
  logic [AW-1:0]     out_idx;
  logic [CW-1:0]     out_col;
  logic [RW-1:0]     out_row;
  logic              shift_en;
  logic [DW-1:0]     pix_in;
  logic              emit;
  logic              wr_strobe;
  logic              border;
  logic [DW:0]       centre_sum;
  logic [7:0]        cmp;
  logic [7:0]        code;
  logic [8:0][DW-1:0] win;

  lbp_line_buffer #(
    .IMG_W (IMG_W),
    .DW    (DW)
  ) u_line_buffer (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .pix_in   (pix_in),
    .win      (win)
  );

  // During FLUSH zeros are shifted in so the last row's centres reach the window; their
  // bottom neighbours are out of image and always masked.
  always_comb begin
    shift_en = 1'b0;
    pix_in   = gray_data;
    emit     = 1'b0;
    case (state)
      S_READ: begin
        shift_en = cap_pend;
        emit     = cap_pend && (cap_idx >= FIRST_EMIT);
      end
      S_FLUSH: begin
        shift_en = 1'b1;
        pix_in   = '0;
        emit     = 1'b1;
      end
      default: ;
    endcase

    centre_sum = {1'b0, win[G_CENTRE]} + {1'b0, thr};
    for (int i = 0; i < 8; i++) begin
      cmp[i] = ({1'b0, win[NBR_IDX[i]]} >= centre_sum);
    end

    border    = (out_row == '0) || (out_row == LAST_ROW) || (out_col == '0) || (out_col == LAST_COL);
    code      = cmp & border_keep(out_row == '0, out_row == LAST_ROW, out_col == '0, out_col == LAST_COL);
    wr_strobe = emit && (WRITE_BORDER || !border);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      thr       <= '0;
      gray_req  <= 1'b0;
      gray_addr <= '0;
      cap_pend  <= 1'b0;
      cap_idx   <= '0;
      out_idx   <= '0;
      out_col   <= '0;
      out_row   <= '0;
      lbp_addr  <= '0;
      lbp_valid <= 1'b0;
      lbp_data  <= '0;
      finish    <= 1'b0;
    end else begin
      lbp_valid <= wr_strobe;
      if (wr_strobe) begin
        lbp_addr <= out_idx;
        lbp_data <= code;
      end
      if (emit) begin
        out_idx <= out_idx + 1'b1;
        if (out_col == LAST_COL) begin
          out_col <= '0;
          out_row <= (out_row == LAST_ROW) ? '0 : out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          thr      <= lbp_thresh;
          gray_req <= 1'b1;
          state    <= S_READ;
        end
        S_READ: begin
          cap_pend <= gray_req && gray_ready;
          if (gray_req && gray_ready) begin
            if (gray_addr == LAST_IDX) gray_req <= 1'b0;
            else                       gray_addr <= gray_addr + 1'b1;
          end
          if (cap_pend) begin
            cap_idx <= cap_idx + 1'b1;
            if (cap_idx == LAST_IDX) state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (out_idx == LAST_IDX) begin
            state  <= S_DONE;
            finish <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lbp_stream_engine.sv
// Scoreboard bench: two engine instances (20x16 skip-border, 8x8 write-border) against a plain LBP model.
module tb_lbp_stream_engine;

  logic clk = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done_flags [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int W      = (g == 0) ? 20 : 8;
    localparam int H      = (g == 0) ? 16 : 8;
    localparam int MODE   = g;
    localparam int N      = W * H;
    localparam int RST_AT = (g == 0) ? 300 : 40;
    localparam int BUDGET = 8 * N + 200;

    logic        reset = 1'b0;
    logic [7:0]  lbp_thresh = '0;
    logic [13:0] gray_addr;
    logic        gray_req;
    logic        gray_ready = 1'b0;
    logic [7:0]  gray_data = '0;
    logic [13:0] lbp_addr;
    logic        lbp_valid;
    logic [7:0]  lbp_data;
    logic        finish;

    int img [N];
    int got [N];
    int exp_addr [$];
    int exp_code [$];
    int n_strobe, first_addr, last_addr;

    lbp_stream_engine #(
      .IMG_W       (W),
      .IMG_H       (H),
      .DW          (8),
      .AW          (14),
      .BORDER_MODE (MODE)
    ) dut (
      .clk        (clk),
      .reset      (reset),
      .lbp_thresh (lbp_thresh),
      .gray_addr  (gray_addr),
      .gray_req   (gray_req),
      .gray_ready (gray_ready),
      .gray_data  (gray_data),
      .lbp_addr   (lbp_addr),
      .lbp_valid  (lbp_valid),
      .lbp_data   (lbp_data),
      .finish     (finish)
    );

    // Reference: for each centre, compare each in-image neighbour against centre+thr in integers.
    function automatic void build_expected(input int thr);
      exp_addr.delete();
      exp_code.delete();
      for (int k = 0; k < N; k++) begin
        int r, c, code, b;
        bit on_border;
        r = k / W;
        c = k % W;
        on_border = (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
        if (on_border && MODE == 0) continue;
        code = 0;
        b = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W)
              if (img[(r + dr) * W + c + dc] >= img[k] + thr) code = code | (1 << b);
            b++;
          end
        end
        exp_addr.push_back(k);
        exp_code.push_back(code);
      end
    endfunction

    function automatic void clear_tally();
      n_strobe   = 0;
      first_addr = -1;
      last_addr  = -1;
      for (int k = 0; k < N; k++) got[k] = -1;
    endfunction

    always @(negedge clk) begin
      if (lbp_valid) begin
        n_strobe++;
        if (first_addr < 0) first_addr = int'(lbp_addr);
        last_addr = int'(lbp_addr);
        if (int'(lbp_addr) < N) got[lbp_addr] = int'(lbp_data);
        if (exp_addr.size() == 0) begin
          checkOutput($sformatf("d%0d unexpected strobe addr", g), int'(lbp_addr), -1);
        end else begin
          checkOutput($sformatf("d%0d lbp_addr", g), int'(lbp_addr), exp_addr.pop_front());
          checkOutput($sformatf("d%0d lbp_data", g), int'(lbp_data), exp_code.pop_front());
        end
      end
    end

    task automatic check_reset_outputs(input string tag);
      checkOutput({tag, " gray_req"},  int'(gray_req),  0);
      checkOutput({tag, " gray_addr"}, int'(gray_addr), 0);
      checkOutput({tag, " lbp_valid"}, int'(lbp_valid), 0);
      checkOutput({tag, " lbp_addr"},  int'(lbp_addr),  0);
      checkOutput({tag, " lbp_data"},  int'(lbp_data),  0);
      checkOutput({tag, " finish"},    int'(finish),    0);
    endtask

    // kind: 0 flat 50, 1 index, 2 random, 3 all 255, 4 narrow random (many ties)
    task automatic applyStimulus(input int kind, input int thr_val, input bit stall, input bit mid_reset);
      int cyc, rd_exp, accepted, acc_addr;
      bit acc, fin, did_reset;
      for (int k = 0; k < N; k++) begin
        case (kind)
          0:       img[k] = 50;
          1:       img[k] = k & 255;
          2:       img[k] = $urandom_range(0, 255);
          3:       img[k] = 255;
          default: img[k] = $urandom_range(100, 103);
        endcase
      end
      reset      = 1'b0;
      gray_ready = 1'b0;
      lbp_thresh = 8'(thr_val);
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs($sformatf("d%0d reset", g));
      build_expected(thr_val);
      clear_tally();
      reset = 1'b1;

      cyc = 0; rd_exp = 0; accepted = 0; fin = 1'b0; did_reset = 1'b0;
      while (!fin && cyc < BUDGET) begin
        gray_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        acc      = gray_req && gray_ready;
        acc_addr = int'(gray_addr);
        fin      = finish;
        if (acc) begin
          checkOutput($sformatf("d%0d read addr", g), acc_addr, rd_exp);
          rd_exp++;
          accepted++;
        end
        @(posedge clk);
        #1;
        lbp_thresh = 8'($urandom_range(0, 255));
        gray_data  = acc ? 8'(img[acc_addr % N]) : 8'($urandom_range(0, 255));
        if (mid_reset && !did_reset && accepted == RST_AT) begin
          did_reset = 1'b1;
          reset = 1'b0;
          @(posedge clk);
          #1;
          check_reset_outputs($sformatf("d%0d midreset", g));
          build_expected(thr_val);
          clear_tally();
          rd_exp = 0;
          accepted = 0;
          lbp_thresh = 8'(thr_val);
          reset = 1'b1;
        end
        cyc++;
      end

      checkOutput($sformatf("d%0d finish seen", g), int'(fin), 1);
      checkOutput($sformatf("d%0d reads", g), rd_exp, N);
      checkOutput($sformatf("d%0d leftover expected", g), exp_addr.size(), 0);
      checkOutput($sformatf("d%0d strobe count", g), n_strobe, MODE ? N : (W - 2) * (H - 2));
      checkOutput($sformatf("d%0d first addr", g), first_addr, MODE ? 0 : W + 1);
      checkOutput($sformatf("d%0d last addr", g), last_addr, MODE ? N - 1 : N - W - 2);
      repeat (3) @(posedge clk);
      #1;
      checkOutput($sformatf("d%0d done lbp_valid", g), int'(lbp_valid), 0);
      checkOutput($sformatf("d%0d done gray_req", g), int'(gray_req), 0);
      checkOutput($sformatf("d%0d done finish", g), int'(finish), 1);
    endtask

    initial begin
      applyStimulus(0, 0, 1'b0, 1'b0);
      checkOutput($sformatf("d%0d flat code", g), got[W + 1], 255);
      applyStimulus(0, 1, 1'b0, 1'b0);
      checkOutput($sformatf("d%0d flat thresh1 code", g), got[W + 1], 0);
      applyStimulus(1, 0, 1'b0, 1'b0);
      checkOutput($sformatf("d%0d index corner code", g), got[0], MODE ? 8'hD0 : -1);
      checkOutput($sformatf("d%0d index inner code", g), got[W + 1], 8'hF0);
      applyStimulus(2, $urandom_range(0, 30), 1'b0, 1'b0);
      applyStimulus(4, $urandom_range(0, 2), 1'b1, 1'b0);
      applyStimulus(2, $urandom_range(0, 30), 1'b1, 1'b1);
      applyStimulus(3, 255, 1'b0, 1'b0);
      checkOutput($sformatf("d%0d thresh255 code", g), got[W + 1], 0);
      applyStimulus(2, 255, 1'b1, 1'b0);
      done_flags[g] = 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: done0=%0d done1=%0d, expected both 1", done_flags[0], done_flags[1]);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    wait (done_flags[0] && done_flags[1]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
